// File: rtl/bitcoin_hash_pkg.sv
// Shared SHA-256 constants, padding words, controller state encoding and
// the rotate/sigma helpers used by the nonce sweeper.
// Optional feature macro: NONCE_EARLY_EXIT_EN (used by bitcoin_nonce_search).
package bitcoin_hash_pkg;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Padding: leading one bit, then bit lengths of the two hashed messages
    localparam logic [31:0] PAD_ONE = 32'h80000000;
    localparam logic [31:0] LEN_P2  = 32'd640;
    localparam logic [31:0] LEN_P3  = 32'd256;

    typedef enum logic [3:0] {
        IDLE, READ,
        P1_INIT, P1_RUN, P1_FIN,
        P2_INIT, P2_RUN, P2_FIN,
        P3_INIT, P3_RUN, P3_FIN,
        WR_H0, WR_FLAG, WR_NONCE
    } state_t;

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rightrotate(x, 2) ^ rightrotate(x, 13) ^ rightrotate(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rightrotate(x, 6) ^ rightrotate(x, 11) ^ rightrotate(x, 25);
    endfunction

endpackage

// File: rtl/bitcoin_nonce_search_core.sv
// One SHA-256 compression engine: working variables a..h, the initial hash
// kept for the final add, and a rolling 16-word message schedule window.
module sha256_round_core
    import bitcoin_hash_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [5:0]        round_i,
    input  logic [7:0][31:0]  init_i,
    input  logic [15:0][31:0] block_i,
    output logic [7:0][31:0]  digest_o
);

    logic [7:0][31:0]  work_q, work_d;
    logic [7:0][31:0]  base_q, base_d;
    logic [15:0][31:0] window_q, window_d;
    logic [31:0]       t1, t2, ch, maj;

    // Load a fresh block or advance one round; window[0] is always W[t]
    always_comb begin
        work_d   = work_q;
        base_d   = base_q;
        window_d = window_q;
        ch  = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
        maj = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
        t1  = work_q[7] + Sigma1(work_q[4]) + ch + K[round_i] + window_q[0];
        t2  = Sigma0(work_q[0]) + maj;
        if (load_i) begin
            work_d   = init_i;
            base_d   = init_i;
            window_d = block_i;
        end else if (step_i) begin
            work_d[7] = work_q[6];
            work_d[6] = work_q[5];
            work_d[5] = work_q[4];
            work_d[4] = work_q[3] + t1;
            work_d[3] = work_q[2];
            work_d[2] = work_q[1];
            work_d[1] = work_q[0];
            work_d[0] = t1 + t2;
            for (int i = 0; i < 15; i++) begin
                window_d[i] = window_q[i + 1];
            end
            window_d[15] = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];
        end
    end

    // Engine registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q   <= '0;
            base_q   <= '0;
            window_q <= '0;
        end else begin
            work_q   <= work_d;
            base_q   <= base_d;
            window_q <= window_d;
        end
    end

    // Digest is the initial hash plus the working variables after round 63
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            digest_o[i] = base_q[i] + work_q[i];
        end
    end

endmodule

// File: rtl/bitcoin_nonce_search.sv
// Double-SHA-256 nonce sweeper: reads a 20-word header, computes the midstate
// once, then hashes NUM_NONCES nonces, streaming each H0 and finally writing
// the found flag and the first winning nonce.
// Optional feature macro: NONCE_EARLY_EXIT_EN (stop sweeping after first match).
module bitcoin_nonce_search
    import bitcoin_hash_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [31:0]       nonce_base,
    input  logic [31:0]       target,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [15:0]       nonceIdx_q, nonceIdx_d;
    logic [ADDR_W-1:0] msgAddr_q, msgAddr_d, outAddr_q, outAddr_d;
    logic [31:0]       nonceBase_q, nonceBase_d, target_q, target_d;
    logic [18:0][31:0] header_q, header_d;
    logic [7:0][31:0]  midstate_q, midstate_d, p2Digest_q, p2Digest_d;
    logic [31:0]       h0_q, h0_d, foundNonce_q, foundNonce_d;
    logic              found_q, found_d;

    logic              coreLoad, coreStep, hit, lastOne;
    logic [7:0][31:0]  coreInit, coreDigest;
    logic [15:0][31:0] coreBlock;
    logic [31:0]       nonce;
    logic [4:0]        hdrIdx;

    assign mem_clk = clk;
    assign nonce   = nonceBase_q + {16'b0, nonceIdx_q};
    assign hdrIdx  = cnt_q[4:0] - 5'd1;

    sha256_round_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (coreLoad),
        .step_i   (coreStep),
        .round_i  (cnt_q[5:0]),
        .init_i   (coreInit),
        .block_i  (coreBlock),
        .digest_o (coreDigest)
    );

    // Controller next state, job bookkeeping and core load/step muxing
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nonceIdx_d   = nonceIdx_q;
        msgAddr_d    = msgAddr_q;
        outAddr_d    = outAddr_q;
        nonceBase_d  = nonceBase_q;
        target_d     = target_q;
        header_d     = header_q;
        midstate_d   = midstate_q;
        p2Digest_d   = p2Digest_q;
        h0_d         = h0_q;
        found_d      = found_q;
        foundNonce_d = foundNonce_q;
        coreLoad     = 1'b0;
        coreStep     = 1'b0;
        coreInit     = '0;
        coreBlock    = '0;
        hit          = 1'b0;
        lastOne      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = READ;
                    cnt_d        = '0;
                    nonceIdx_d   = '0;
                    msgAddr_d    = message_addr;
                    outAddr_d    = output_addr;
                    nonceBase_d  = nonce_base;
                    target_d     = target;
                    found_d      = 1'b0;
                    foundNonce_d = '0;
                end
            end
            READ: begin
                if (cnt_q >= 7'd1 && cnt_q <= 7'd19) begin
                    header_d[hdrIdx] = mem_read_data;
                end
                if (cnt_q == 7'd20) begin
                    state_d = P1_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            P1_INIT: begin
                coreLoad = 1'b1;
                for (int i = 0; i < 8; i++) coreInit[i] = IV[i];
                for (int i = 0; i < 16; i++) coreBlock[i] = header_q[i];
                state_d = P1_RUN;
                cnt_d   = '0;
            end
            P2_INIT: begin
                coreLoad      = 1'b1;
                coreInit      = midstate_q;
                coreBlock[0]  = header_q[16];
                coreBlock[1]  = header_q[17];
                coreBlock[2]  = header_q[18];
                coreBlock[3]  = nonce;
                coreBlock[4]  = PAD_ONE;
                coreBlock[15] = LEN_P2;
                state_d = P2_RUN;
                cnt_d   = '0;
            end
            P3_INIT: begin
                coreLoad = 1'b1;
                for (int i = 0; i < 8; i++) coreInit[i] = IV[i];
                for (int i = 0; i < 8; i++) coreBlock[i] = p2Digest_q[i];
                coreBlock[8]  = PAD_ONE;
                coreBlock[15] = LEN_P3;
                state_d = P3_RUN;
                cnt_d   = '0;
            end
            P1_RUN, P2_RUN, P3_RUN: begin
                coreStep = 1'b1;
                cnt_d    = cnt_q + 7'd1;
                if (cnt_q == 7'd63) begin
                    cnt_d   = '0;
                    state_d = (state_q == P1_RUN) ? P1_FIN :
                              (state_q == P2_RUN) ? P2_FIN : P3_FIN;
                end
            end
            P1_FIN: begin
                midstate_d = coreDigest;
                state_d    = P2_INIT;
            end
            P2_FIN: begin
                p2Digest_d = coreDigest;
                state_d    = P3_INIT;
            end
            P3_FIN: begin
                h0_d    = coreDigest[0];
                state_d = WR_H0;
            end
            WR_H0: begin
                hit = !found_q && (h0_q < target_q);
                if (hit) begin
                    found_d      = 1'b1;
                    foundNonce_d = nonce;
                end
`ifdef NONCE_EARLY_EXIT_EN
                lastOne = hit || (nonceIdx_q == LAST_IDX);
`else
                lastOne = (nonceIdx_q == LAST_IDX);
`endif
                if (lastOne) begin
                    state_d = WR_FLAG;
                end else begin
                    nonceIdx_d = nonceIdx_q + 16'd1;
                    state_d    = P2_INIT;
                end
            end
            WR_FLAG:  state_d = WR_NONCE;
            WR_NONCE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Controller and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            nonceIdx_q   <= '0;
            msgAddr_q    <= '0;
            outAddr_q    <= '0;
            nonceBase_q  <= '0;
            target_q     <= '0;
            header_q     <= '0;
            midstate_q   <= '0;
            p2Digest_q   <= '0;
            h0_q         <= '0;
            found_q      <= 1'b0;
            foundNonce_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nonceIdx_q   <= nonceIdx_d;
            msgAddr_q    <= msgAddr_d;
            outAddr_q    <= outAddr_d;
            nonceBase_q  <= nonceBase_d;
            target_q     <= target_d;
            header_q     <= header_d;
            midstate_q   <= midstate_d;
            p2Digest_q   <= p2Digest_d;
            h0_q         <= h0_d;
            found_q      <= found_d;
            foundNonce_q <= foundNonce_d;
        end
    end

    // Memory port and done decode straight from the registered state
    always_comb begin
        done           = (state_q == IDLE);
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (state_q)
            READ: begin
                if (cnt_q < 7'd20) mem_addr = msgAddr_q + ADDR_W'(cnt_q);
            end
            WR_H0: begin
                mem_we         = 1'b1;
                mem_addr       = outAddr_q + ADDR_W'(nonceIdx_q);
                mem_write_data = h0_q;
            end
            WR_FLAG: begin
                mem_we         = 1'b1;
                mem_addr       = outAddr_q + ADDR_W'(NUM_NONCES);
                mem_write_data = {31'b0, found_q};
            end
            WR_NONCE: begin
                mem_we         = 1'b1;
                mem_addr       = outAddr_q + ADDR_W'(NUM_NONCES + 1);
                mem_write_data = foundNonce_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// Scoreboard bench for bitcoin_nonce_search: a plain SHA-256 reference model
// predicts every memory write, a monitor compares writes as they appear.
// Honours NONCE_EARLY_EXIT_EN when predicting the write sequence.
module tb_bitcoin_nonce_search;

    localparam int NUM_NONCES = 16;
    localparam int ADDR_W     = 16;
    localparam logic [15:0] MSG = 16'h0100;
    localparam logic [15:0] OUT = 16'h0200;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IVT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] message_addr, output_addr;
    logic [31:0]       nonce_base, target;
    logic              done, mem_clk, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data, mem_read_data;

    logic [31:0] mem [65536];
    logic        tbLoad = 1'b0;
    logic [15:0] tbAddr = '0;
    logic [31:0] tbData = '0;

    logic [31:0] hdr [20];
    wr_t         expQ [$];
    int          checks = 0;
    int          failures = 0;
    int          writesSeen = 0;

    bitcoin_nonce_search #(.NUM_NONCES(NUM_NONCES), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .message_addr   (message_addr),
        .output_addr    (output_addr),
        .nonce_base     (nonce_base),
        .target         (target),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous word memory; the bench preloads it through its own port
    always @(posedge mem_clk) begin
        if (tbLoad) mem[tbAddr] <= tbData;
        else if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    // Monitor: every DUT write is matched against the next predicted write
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            wr_t e;
            writesSeen++;
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write addr=%h data=%h (none expected)", mem_addr, mem_write_data);
            end else begin
                e = expQ.pop_front();
                if (mem_addr !== e.addr || mem_write_data !== e.data) begin
                    failures++;
                    $display("[TB] FAIL mem_write actual addr=%h data=%h required addr=%h data=%h",
                             mem_addr, mem_write_data, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] ivPacked();
        logic [7:0][31:0] r;
        for (int i = 0; i < 8; i++) r[i] = IVT[i];
        return r;
    endfunction

    // Textbook SHA-256 compression with a full 64-word schedule
    function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [7:0][31:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = hin[i] + v[i];
        return r;
    endfunction

    // First word of the double hash of the 80-byte header with this nonce
    function automatic logic [31:0] h0Of(input logic [31:0] nonce);
        logic [15:0][31:0] b1, b2, b3;
        logic [7:0][31:0]  mid, d2, d3;
        for (int i = 0; i < 16; i++) b1[i] = hdr[i];
        mid = compress(ivPacked(), b1);
        b2 = '0;
        b2[0] = hdr[16]; b2[1] = hdr[17]; b2[2] = hdr[18];
        b2[3] = nonce; b2[4] = 32'h80000000; b2[15] = 32'd640;
        d2 = compress(mid, b2);
        b3 = '0;
        for (int i = 0; i < 8; i++) b3[i] = d2[i];
        b3[8] = 32'h80000000; b3[15] = 32'd256;
        d3 = compress(ivPacked(), b3);
        return d3[0];
    endfunction

    // Predict the whole write sequence and the done latency of one job
    task automatic buildExpect(input logic [31:0] base, input logic [31:0] tgt, input logic [15:0] out,
                               output int lat, output int nWr);
        logic        fnd = 1'b0;
        logic [31:0] fNonce = '0;
        logic [31:0] h;
        nWr = 0;
        for (int n = 0; n < NUM_NONCES; n++) begin
            h = h0Of(base + 32'(n));
            expQ.push_back('{addr: out + 16'(n), data: h});
            nWr++;
            if (!fnd && h < tgt) begin
                fnd = 1'b1;
                fNonce = base + 32'(n);
`ifdef NONCE_EARLY_EXIT_EN
                break;
`endif
            end
        end
        expQ.push_back('{addr: out + 16'(NUM_NONCES), data: {31'b0, fnd}});
        expQ.push_back('{addr: out + 16'(NUM_NONCES + 1), data: fNonce});
        lat = 21 + 66 + 133 * nWr + 2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic loadHeader();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tbLoad = 1'b1;
            tbAddr = MSG + 16'(i);
            tbData = hdr[i];
        end
        @(negedge clk);
        tbLoad = 1'b0;
    endtask

    // Run one job end to end; pulseAt>0 pulses start during that cycle of the job
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] tgt,
                                 input logic [15:0] out, input int pulseAt);
        int lat, nWr, w0, cyc;
        buildExpect(base, tgt, out, lat, nWr);
        w0 = writesSeen;
        @(negedge clk);
        message_addr = MSG;
        output_addr  = out;
        nonce_base   = base;
        target       = tgt;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        message_addr = 16'($urandom);
        output_addr  = 16'($urandom);
        nonce_base   = $urandom;
        target       = $urandom;
        checkOutput("done_fall", {31'b0, done}, 32'd0);
        cyc = 0;
        while (!done && cyc < lat + 50) begin
            @(posedge clk);
            cyc++;
            #1;
            start = (cyc == pulseAt);
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=not_done required=done_after_%0d", lat);
        end else begin
            checkOutput("latency", 32'(cyc), 32'(lat));
        end
        repeat (4) @(negedge clk);
        checkOutput("write_count", 32'(writesSeen - w0), 32'(nWr + 2));
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    endtask

    // Abort a job in round 29 of phase 2 for nonce 3, then rerun it cleanly
    task automatic abortAndRerun(input logic [31:0] base);
        int lat, nWr, w0;
        buildExpect(base, 32'd0, OUT, lat, nWr);
        w0 = writesSeen;
        @(negedge clk);
        message_addr = MSG; output_addr = OUT; nonce_base = base; target = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (516) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd1);
        checkOutput("abort_partial_writes", 32'(writesSeen - w0), 32'd3);
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(base, 32'd0, OUT, 0);
    endtask

    initial begin
        logic [31:0] base, tgt;
        logic [31:0] h [6];
        bit ok;

        reset = 1'b1; start = 1'b0;
        message_addr = '0; output_addr = '0; nonce_base = '0; target = '0;
        for (int i = 0; i < 20; i++) hdr[i] = $urandom;
        #12;
        checkOutput("reset_done", {31'b0, done}, 32'd1);
        checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", mem_write_data, 32'd0);
        checkOutput("mem_clk_follows_clk", {31'b0, mem_clk}, {31'b0, clk});
        @(negedge clk);
        reset = 1'b0;
        loadHeader();

        $display("[TB] job: base 0, target all-ones");
        applyStimulus(32'd0, 32'hFFFFFFFF, OUT, 0);
        $display("[TB] job: base 0, target 0, wrapping output region");
        applyStimulus(32'd0, 32'd0, 16'hFFF8, 0);
        $display("[TB] job: nonce wrap from 0xFFFFFFFE");
        applyStimulus(32'hFFFFFFFE, 32'h80000000, OUT, 0);

        $display("[TB] job: first match at nonce index 5");
        ok = 1'b0;
        base = '0;
        tgt = '0;
        for (int t = 0; t < 200 && !ok; t++) begin
            base = $urandom;
            for (int i = 0; i < 6; i++) h[i] = h0Of(base + 32'(i));
            ok = (h[5] != 32'hFFFFFFFF);
            for (int i = 0; i < 5; i++) if (h[i] <= h[5]) ok = 1'b0;
            tgt = h[5] + 32'd1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL match5_setup actual=no_base_found required=base_found");
        end else begin
            applyStimulus(base, tgt, OUT, 0);
            checkOutput("match5_flag", mem[OUT + 16'(NUM_NONCES)], 32'd1);
            checkOutput("match5_nonce", mem[OUT + 16'(NUM_NONCES + 1)], base + 32'd5);
        end

        $display("[TB] job: reset in phase 2 of nonce 3, then rerun");
        abortAndRerun(32'h0000_1000);

        $display("[TB] job: start pulsed during phase 1");
        applyStimulus(32'h12345678, 32'd0, OUT, 50);

        $display("[TB] job: random base and target");
        applyStimulus($urandom, $urandom, OUT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitcoin_nonce_search.md
Name: bitcoin_nonce_search

Overview:
Parametrised Bitcoin double-SHA-256 nonce sweeper for the hashing subsystem.
- Reads a 20-word block header from word-addressed memory and computes the first-block midstate once.
- Sweeps NUM_NONCES consecutive nonces from a runtime base, streaming each final H0 to memory as soon as it is produced.
- Compares each H0 against a runtime target and writes a found flag plus the first winning nonce.

Parameters:
NUM_NONCES, 16, nonces swept per start (1..65535)
ADDR_W, 16, memory word-address width

Ports:
clk  in  1  single clock; memory also clocked on it
reset  in  1  asynchronous, active-high reset
start  in  1  begin a job; sampled in IDLE only
message_addr  in  ADDR_W  base of the 20 header words
output_addr  in  ADDR_W  base of the result region
nonce_base  in  32  first nonce
target  in  32  unsigned threshold for H0
done  out  1  high while in IDLE
mem_clk  out  1  equals clk
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word address
mem_write_data  out  32  write data
mem_read_data  in  32  read data, valid one cycle after address

Behaviour:
- Interface: one clock clk; reset is asynchronous, active-high, on port reset.
- Reset values: state IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0, found flag and found nonce 0.
- Inputs message_addr, output_addr, nonce_base and target are latched on the start-accept edge and stay stable internally for the whole job.
- States: IDLE, READ, P1_INIT, P1_RUN, P1_FIN, P2_INIT, P2_RUN, P2_FIN, P3_INIT, P3_RUN, P3_FIN, WR_H0, WR_FLAG, WR_NONCE.
- IDLE: when start=1, go to READ. When start=0, stay in IDLE.
- READ: 21 cycles. Issues addresses message_addr+0..19 with mem_we=0 and captures each word one cycle later.
- Each INIT/RUN/FIN phase takes 66 cycles: 1 load, 64 rounds at one per cycle, 1 digest add.
- Message schedule uses a rolling 16-word window. No 64-entry array.
- Phase 1: header words 0..15 with IV constants; the resulting midstate is held for the whole sweep.
- Phase 2: words 16..18, then the nonce, 0x80000000, ten zero words, then 640. Starts from the midstate.
- Phase 3: the 8 phase-2 digest words, then 0x80000000, six zero words, then 256. Starts from IV.
- WR_H0: one cycle with mem_we=1, mem_addr=output_addr+n, mem_write_data=H0. Here n is the nonce index.
- Nonce n = nonce_base+n, mod 2^32 with wrap-around. Address sums wrap at ADDR_W bits.
- Match rule: H0 < target, unsigned and strict. Only the first match sets found and latches its nonce; later matches are ignored.
- After the last nonce:
  - WR_FLAG writes {31'b0, found} to output_addr+NUM_NONCES.
  - WR_NONCE writes the found nonce (0 if none) to output_addr+NUM_NONCES+1.
  - Then IDLE.
- mem_we is 1 only in the WR_* states.
- Latency: done falls on the cycle after the accept edge. It rises again 21+66+133*NUM_NONCES+2 cycles after the accept edge.
- start while busy is ignored. start held high through completion launches a new job on the next IDLE cycle.
- Reset mid-job: immediate IDLE with mem_we=0. Partial results already in memory are left as written; no further writes occur.

Optional Feature:
Macro NONCE_EARLY_EXIT_EN.
- Defined: after the WR_H0 of the first matching nonce, jump straight to WR_FLAG; remaining nonces are neither computed nor written.
- Undefined: the full sweep always runs, giving fixed latency.

Decomposition:
- Package bitcoin_hash_pkg holds:
  - K[64] round constants and the IV words.
  - Padding constants 0x80000000, 640 and 256.
  - The state enum.
  - rightrotate, sigma and Sigma functions.
- Sub-module sha256_round_core: registered a..h plus the 16-word schedule window. Controls: load(state, w[0..15]) and step. Exposes the digest. One instance, reused for all three phases.

Test Plan:
- Standard 20-word header, nonce_base=0, target=0xFFFFFFFF, NUM_NONCES=16 -> 16 H0 words match the golden model; flag=1; nonce=0; done rises exactly 2217 cycles after accept.
- Same header, target=0 -> all 16 H0 written; flag word 0; nonce word 0.
- nonce_base=0xFFFFFFFE, NUM_NONCES=4 -> H0 for nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 match the model (wrap verified).
- target = model H0[5] + 1, with the model showing H0[0..4] >= target -> found nonce = base+5.
  - NONCE_EARLY_EXIT_EN defined: only output_addr+0..5 written, then flag and nonce.
  - Undefined: all 16 written.
- Assert reset in the 30th round of phase 2 for nonce 3 -> mem_we=0 and done=1 in the same cycle; restart gives results identical to a clean run.
- Pulse start during phase 1 -> ignored; no second job; write count and cycle count unchanged.
